// File: rtl/cache_controller_if.sv
// cache_controller_if
//   Bundles the MEM-stage request/response signals and the SramController
//   side of the read cache into one interface.
//   MEM side   : MEM_R_EN, MEM_W_EN, address, wdata  -> cache
//                rdata, ready                        <- cache
//   SRAM side  : sram_address, sram_wdata,
//                sram_read, sram_write               <- cache
//                sram_rdata, sram_ready              -> cache
//   Modports: slave = the cache controller, master = its environment
//   (pipeline plus SramController).
interface cache_controller_if;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_read;
  logic        sram_write;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  modport slave (
    input  MEM_R_EN, MEM_W_EN, address, wdata, sram_rdata, sram_ready,
    output rdata, ready, sram_address, sram_wdata, sram_read, sram_write
  );

  modport master (
    output MEM_R_EN, MEM_W_EN, address, wdata, sram_rdata, sram_ready,
    input  rdata, ready, sram_address, sram_wdata, sram_read, sram_write
  );
endinterface

// File: rtl/cache_controller.sv
// cache_controller
//   2-way set-associative, write-through read cache sitting between the MEM
//   stage and the SramController. Read hits complete in the request cycle;
//   read misses fetch a 64-bit block (two words). Every store goes to SRAM and
//   invalidates a matching cached line. ready=0 freezes the pipeline.
// Ports
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset (clears valid and LRU bits)
//   bus  : cache_controller_if.slave (MEM-stage and SramController signals)
module cache_controller #(
  parameter int BASE_ADDR = 1024,
  parameter int INDEX_W   = 6,
  parameter int TAG_W     = 10
) (
  input  logic                clk,
  input  logic                rst,
  cache_controller_if.slave   bus
);

  localparam int SETS = 1 << INDEX_W;
  localparam int HI   = INDEX_W + TAG_W;
  localparam logic [31:0] BASE_WORD = 32'(BASE_ADDR) >> 2;

  typedef enum logic [1:0] {IDLE, READ_MISS, WRITE} state_t;

  state_t state;
  state_t state_next;

  // Word address relative to the data-memory base; bit 0 selects the word
  // inside the 64-bit block. Working on word addresses keeps every bit used.
  logic [HI:0]          word_addr;
  logic                 sel;
  logic [INDEX_W-1:0]   index;
  logic [TAG_W-1:0]     tag;

  logic [SETS-1:0]      valid0;
  logic [SETS-1:0]      valid1;
  logic [SETS-1:0]      lru;
  logic [TAG_W-1:0]     tag0  [SETS];
  logic [TAG_W-1:0]     tag1  [SETS];
  logic [63:0]          data0 [SETS];
  logic [63:0]          data1 [SETS];

  logic                 hit0;
  logic                 hit1;
  logic                 hit;
  logic [63:0]          hit_block;
  logic                 victim;
  logic                 fill;
  logic                 read_hit;
  logic                 write_req;

  assign word_addr = bus.address[HI+2:2] - BASE_WORD[HI:0];
  assign sel       = word_addr[0];
  assign index     = word_addr[1 +: INDEX_W];
  assign tag       = word_addr[1+INDEX_W +: TAG_W];

  assign bus.sram_address = bus.address;
  assign bus.sram_wdata   = bus.wdata;

  // Hit detection is masked by rst so nothing is reported as a hit while
  // the valid bits are being cleared.
  assign hit0      = ~rst & valid0[index] & (tag0[index] == tag);
  assign hit1      = ~rst & valid1[index] & (tag1[index] == tag);
  assign hit       = hit0 | hit1;
  assign hit_block = hit0 ? data0[index] : data1[index];

  // Replacement: fill an empty way first (way0 before way1), otherwise the
  // way the LRU bit names.
  assign victim = ~valid0[index] ? 1'b0 :
                  ~valid1[index] ? 1'b1 : lru[index];

  assign write_req = (state == IDLE) & bus.MEM_W_EN;
  assign read_hit  = (state == IDLE) & ~bus.MEM_W_EN & bus.MEM_R_EN & hit;
  assign fill      = (state == READ_MISS) & bus.sram_ready;

  // State register; reset returns to IDLE at once so the SRAM request
  // strobes, decoded from the state, drop immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: the store path has priority over loads, and each SRAM
  // transaction ends on the edge where sram_ready is seen.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (bus.MEM_W_EN) begin
          state_next = WRITE;
        end else if (bus.MEM_R_EN && !hit) begin
          state_next = READ_MISS;
        end
      end
      READ_MISS: begin
        if (bus.sram_ready) begin
          state_next = IDLE;
        end
      end
      WRITE: begin
        if (bus.sram_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: ready follows sram_ready while a transaction is in
  // flight, so the pipeline releases in the same cycle the data arrives.
  always_comb begin
    bus.ready      = 1'b0;
    bus.rdata      = 32'd0;
    bus.sram_read  = 1'b0;
    bus.sram_write = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.MEM_W_EN) begin
          bus.ready = 1'b0;
        end else if (bus.MEM_R_EN) begin
          bus.ready = hit;
          if (hit) begin
            bus.rdata = sel ? hit_block[63:32] : hit_block[31:0];
          end
        end else begin
          bus.ready = 1'b1;
        end
      end
      READ_MISS: begin
        bus.sram_read = 1'b1;
        bus.ready     = bus.sram_ready;
        if (bus.sram_ready) begin
          bus.rdata = sel ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];
        end
      end
      WRITE: begin
        bus.sram_write = 1'b1;
        bus.ready      = bus.sram_ready;
      end
      default: ;
    endcase
  end

  // Valid and LRU bookkeeping. A store that hits invalidates the line
  // rather than updating it, keeping the cache trivially coherent with SRAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else begin
      if (fill) begin
        if (victim) begin
          valid1[index] <= 1'b1;
        end else begin
          valid0[index] <= 1'b1;
        end
        lru[index] <= ~victim;
      end else if (read_hit) begin
        lru[index] <= hit0;
      end
      if (write_req) begin
        if (hit0) begin
          valid0[index] <= 1'b0;
        end
        if (hit1) begin
          valid1[index] <= 1'b0;
        end
      end
    end
  end

  // Tag and data arrays need no reset: they are only meaningful when the
  // matching valid bit is set.
  always_ff @(posedge clk) begin
    if (fill) begin
      if (victim) begin
        tag1[index]  <= tag;
        data1[index] <= bus.sram_rdata;
      end else begin
        tag0[index]  <= tag;
        data0[index] <= bus.sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller
//   Scoreboard bench for cache_controller. A small SRAM model answers
//   requests after a fixed latency. The reference model tracks, per set, the
//   resident tags in recency order and the current memory contents, and from
//   that predicts the response latency and load data of every request. The
//   driver pushes predictions into a queue; an independent monitor pops and
//   compares whenever the controller completes a request.
module tb_cache_controller;

  localparam int BASE = 1024;
  localparam int LAT  = 5;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    int          lat;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  cache_controller_if bus();

  cache_controller #(
    .BASE_ADDR(BASE),
    .INDEX_W(6),
    .TAG_W(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Default memory contents; block 128 (address 1024) holds the known
  // pattern {BBBB, AAAA}.
  function automatic logic [63:0] pattern(int unsigned blk);
    if (blk == 128) return {32'h0000BBBB, 32'h0000AAAA};
    return {32'hC0DE0000 | (blk * 2 + 1), 32'hC0DE0000 | (blk * 2)};
  endfunction

  // SRAM model: answers a held request after LAT cycles with one ready pulse.
  logic [63:0] sram_mem [4096];
  bit          written  [4096];
  int          sram_cnt;
  logic [11:0] sram_idx;

  assign sram_idx        = bus.sram_address[14:3];
  assign bus.sram_ready  = (sram_cnt == LAT);
  assign bus.sram_rdata  = written[sram_idx] ? sram_mem[sram_idx] : pattern(32'(sram_idx));

  always @(posedge clk or posedge rst) begin
    if (rst) sram_cnt <= 0;
    else if ((bus.sram_read || bus.sram_write) && sram_cnt < LAT) sram_cnt <= sram_cnt + 1;
    else sram_cnt <= 0;
  end

  always @(posedge clk) begin
    if (bus.sram_write && bus.sram_ready) begin
      if (bus.sram_address[2]) sram_mem[sram_idx] <= {bus.sram_wdata, bus.sram_rdata[31:0]};
      else sram_mem[sram_idx] <= {bus.sram_rdata[63:32], bus.sram_wdata};
      written[sram_idx] <= 1'b1;
    end
  end

  // Reference model: per set up to two tags, least recently used first.
  logic [63:0] ref_mem [int];
  int          m_tag [64][2];
  int          m_cnt [64];

  function automatic logic [63:0] refBlock(int blk);
    if (ref_mem.exists(blk)) return ref_mem[blk];
    return pattern(blk);
  endfunction

  task automatic modelReset();
    for (int s = 0; s < 64; s++) m_cnt[s] = 0;
  endtask

  // Returns 1 on a hit; on a miss the line is brought in, evicting the
  // least recently used tag when the set is full.
  function automatic bit modelRead(int addr);
    int s = ((addr - BASE) >> 3) & 63;
    int t = ((addr - BASE) >> 9) & 1023;
    for (int i = 0; i < m_cnt[s]; i++) begin
      if (m_tag[s][i] == t) begin
        if (i == 0 && m_cnt[s] == 2) begin
          m_tag[s][0] = m_tag[s][1];
          m_tag[s][1] = t;
        end
        return 1'b1;
      end
    end
    if (m_cnt[s] == 2) begin
      m_tag[s][0] = m_tag[s][1];
      m_tag[s][1] = t;
    end else begin
      m_tag[s][m_cnt[s]] = t;
      m_cnt[s]++;
    end
    return 1'b0;
  endfunction

  function automatic void modelWrite(int addr, logic [31:0] d);
    int s = ((addr - BASE) >> 3) & 63;
    int t = ((addr - BASE) >> 9) & 1023;
    logic [63:0] b = refBlock(addr >> 3);
    for (int i = 0; i < m_cnt[s]; i++) begin
      if (m_tag[s][i] == t) begin
        if (i == 0 && m_cnt[s] == 2) m_tag[s][0] = m_tag[s][1];
        m_cnt[s]--;
        break;
      end
    end
    if (addr[2]) b[63:32] = d;
    else b[31:0] = d;
    ref_mem[addr >> 3] = b;
  endfunction

  task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Issues one request, records its prediction, and holds it until ready.
  task automatic applyStimulus(bit rd, bit wr, int addr, logic [31:0] d, string name);
    exp_t e;
    int   n = 0;
    logic [63:0] b;
    @(posedge clk);
    #1;
    e.name    = name;
    e.is_read = rd && !wr;
    if (wr) begin
      modelWrite(addr, d);
      e.lat  = LAT + 2;
      e.data = 32'd0;
    end else begin
      b      = refBlock(addr >> 3);
      e.lat  = modelRead(addr) ? 1 : LAT + 2;
      e.data = addr[2] ? b[63:32] : b[31:0];
    end
    exp_q.push_back(e);
    bus.MEM_R_EN = rd;
    bus.MEM_W_EN = wr;
    bus.address  = addr;
    bus.wdata    = d;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ready && n < 50);
    if (!bus.ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: ready=%0b after %0d cycles, required 1", name, bus.ready, n);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
  endtask

  // Monitor: pops a prediction whenever a request completes.
  initial begin
    exp_t e;
    int   cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0;
      end else begin
        if (bus.sram_read && bus.sram_write) checkOutput("read/write exclusive", 64'(bus.sram_write), 64'd0);
        if (bus.MEM_R_EN || bus.MEM_W_EN) begin
          cyc++;
          if (bus.ready) begin
            if (exp_q.size() == 0) begin
              checkOutput("unexpected completion", 64'(bus.ready), 64'd0);
            end else begin
              e = exp_q.pop_front();
              checkOutput({e.name, " latency"}, 64'(cyc), 64'(e.lat));
              if (e.is_read) checkOutput({e.name, " rdata"}, 64'(bus.rdata), 64'(e.data));
              else checkOutput({e.name, " sram_write at ack"}, 64'(bus.sram_write), 64'd1);
              if (e.lat == 1) checkOutput({e.name, " sram_read on hit"}, 64'(bus.sram_read), 64'd0);
            end
            cyc = 0;
          end
        end
      end
    end
  end

  initial begin
    rst          = 1'b1;
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
    bus.address  = BASE;
    bus.wdata    = 32'd0;
    modelReset();
    #2;
    checkOutput("reset ready idle", 64'(bus.ready), 64'd1);
    checkOutput("reset rdata", 64'(bus.rdata), 64'd0);
    checkOutput("reset sram_read", 64'(bus.sram_read), 64'd0);
    checkOutput("reset sram_write", 64'(bus.sram_write), 64'd0);
    bus.MEM_R_EN = 1'b1;
    #1;
    checkOutput("reset ready with load", 64'(bus.ready), 64'd0);
    bus.MEM_R_EN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] miss then hit on block 1024");
    applyStimulus(1, 0, 1024, 0, "t1 read 1024");
    @(negedge clk);
    checkOutput("t1 sram_read dropped", 64'(bus.sram_read), 64'd0);
    applyStimulus(1, 0, 1028, 0, "t2 read 1028");

    $display("[TB] LRU eviction in set 0");
    applyStimulus(1, 0, 1024, 0, "t3 read 1024");
    applyStimulus(1, 0, 1536, 0, "t3 read 1536");
    applyStimulus(1, 0, 1024, 0, "t3 reread 1024");
    applyStimulus(1, 0, 2048, 0, "t3 read 2048");
    applyStimulus(1, 0, 1024, 0, "t3 hit 1024");
    applyStimulus(1, 0, 1536, 0, "t3 miss 1536");

    $display("[TB] write-through invalidation");
    applyStimulus(1, 0, 1024, 0, "t4 fill 1024");
    applyStimulus(0, 1, 1024, 32'h1234, "t4 write 1024");
    applyStimulus(1, 0, 1024, 0, "t4 read 1024");

    $display("[TB] reset during a miss");
    @(posedge clk);
    #1;
    bus.MEM_R_EN = 1'b1;
    bus.address  = BASE + (5 << 9);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t5 sram_read before reset", 64'(bus.sram_read), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("t5 sram_read in reset", 64'(bus.sram_read), 64'd0);
    checkOutput("t5 ready in reset with load", 64'(bus.ready), 64'd0);
    bus.MEM_R_EN = 1'b0;
    #1;
    checkOutput("t5 ready in reset idle", 64'(bus.ready), 64'd1);
    exp_q.delete();
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1, 0, 1024, 0, "t5 read 1024");

    $display("[TB] idle cycles");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("t6 idle ready", 64'(bus.ready), 64'd1);
      checkOutput("t6 idle sram", 64'({bus.sram_read, bus.sram_write}), 64'd0);
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      int op   = $urandom_range(0, 99);
      int addr = BASE + ($urandom_range(0, 3) << 9) + ($urandom_range(0, 3) << 3)
                 + ($urandom_range(0, 1) << 2);
      if (op < 25) applyStimulus(0, 1, addr, $urandom, "rand write");
      else if (op < 90) applyStimulus(1, 0, addr, 0, "rand read");
      else @(posedge clk);
    end

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) checkOutput("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
